// File: rtl/reshape_out.sv
// -----------------------------------------------------------------------------
// reshape_out
//
// Takes one full result frame from the PE array (PE_COL*PE_ROW elements packed
// into din) and serialises it into a stream of single-element write beats for
// the output store. Each beat carries one element (optionally ReLU-clamped) and
// its store address, which is base_addr + element index, modulo 2^AWIDTH.
// A one-cycle done pulse follows the last beat.
//
// Ports
//   clk         : clock, all logic on the rising edge
//   rst_n       : synchronous, active-low reset
//   work_mode   : 00 idle (no frames accepted), 01/10 plain copy, 11 ReLU
//   din         : packed frame, element k at [N*DWIDTH-1-k*DWIDTH -: DWIDTH]
//   in_valid    : din/base_addr hold a frame to accept
//   in_ready    : block is idle and willing to accept a frame
//   base_addr   : store address of element 0, captured with the frame
//   dout        : current serialised element
//   store_addr  : store address of dout
//   out_valid   : dout/store_addr hold a beat
//   out_ready   : store accepts the current beat
//   done        : single-cycle pulse after the final beat of a frame
// -----------------------------------------------------------------------------
module reshape_out #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 10,
  parameter int PE_COL = 4,
  parameter int PE_ROW = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [1:0]                         work_mode,
  input  logic [PE_COL*PE_ROW*DWIDTH-1:0]    din,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [AWIDTH-1:0]                  base_addr,
  output logic [DWIDTH-1:0]                  dout,
  output logic [AWIDTH-1:0]                  store_addr,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               done
);

  localparam int N    = PE_COL * PE_ROW;
  // idx must reach N-1; keep at least one bit for the degenerate N=1 case.
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  // Common width for adding the index to the address regardless of which
  // of the two is wider; the sum is then truncated to AWIDTH.
  localparam int EXTW = (IDXW > AWIDTH) ? IDXW : AWIDTH;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [DWIDTH-1:0] frame_q [N];
  logic [AWIDTH-1:0] base_q;
  logic              relu_q;

  logic              mode_active;
  logic              accept;
  logic              beat_xfer;
  logic [DWIDTH-1:0] elem;
  logic [EXTW-1:0]   idx_wide;
  logic [EXTW-1:0]   addr_wide;

  assign mode_active = (work_mode != 2'b00);

  // in_ready is gated by rst_n so that it stays low for the whole time reset
  // is asserted, not just from the first reset edge onward.
  assign in_ready  = rst_n && (state_q == IDLE) && mode_active;
  assign accept    = (state_q == IDLE) && mode_active && in_valid;
  assign beat_xfer = (state_q == SHIFT) && out_ready;

  // State register and beat index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic. The index only advances on an accepted beat, which is
  // what keeps dout/store_addr stable while the store stalls us. Leaving SHIFT
  // resets idx so it never exceeds N-1.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        if (beat_xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Frame capture. The whole frame, base address and the ReLU decision are
  // latched at accept, so later work_mode or din changes cannot disturb a
  // frame that is already being streamed out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        frame_q[k] <= '0;
      end
      base_q <= '0;
      relu_q <= 1'b0;
    end else if (accept) begin
      for (int k = 0; k < N; k++) begin
        frame_q[k] <= din[N*DWIDTH-1-k*DWIDTH -: DWIDTH];
      end
      base_q <= base_addr;
      relu_q <= (work_mode == 2'b11);
    end
  end

  assign elem      = frame_q[idx_q];
  assign idx_wide  = EXTW'(idx_q);
  assign addr_wide = EXTW'(base_q) + idx_wide;

  // Beat outputs are driven only in SHIFT and held at zero otherwise, so the
  // data/address bus is quiet whenever out_valid is low.
  always_comb begin
    out_valid  = 1'b0;
    done       = 1'b0;
    dout       = '0;
    store_addr = '0;
    case (state_q)
      SHIFT: begin
        out_valid  = 1'b1;
        store_addr = addr_wide[AWIDTH-1:0];
        if (relu_q && elem[DWIDTH-1]) begin
          dout = '0;
        end else begin
          dout = elem;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

endmodule
